// File: rtl/rvfi_retire_rob_if.sv
// Dispatch / writeback / monitor bundle for rvfi_retire_rob.
// master = surrounding pipeline and monitor, slave = the retirement buffer.
interface rvfi_retire_rob_if #(
  parameter int DEPTH = 8
);
  localparam int TAGW = $clog2(DEPTH);

  logic            alloc_req;
  logic            alloc_ready;
  logic [TAGW-1:0] alloc_tag;
  logic            wb_valid;
  logic [TAGW-1:0] wb_tag;
  logic [310:0]    wb_pkt;
  logic            flush;
  logic            mon_valid;
  logic [63:0]     mon_order;
  logic            mon_halt;
  logic [310:0]    mon_pkt;
  logic [TAGW:0]   occupancy;
  logic            error;

  modport master (
    output alloc_req, wb_valid, wb_tag, wb_pkt, flush,
    input  alloc_ready, alloc_tag, mon_valid, mon_order, mon_halt, mon_pkt,
           occupancy, error
  );

  modport slave (
    input  alloc_req, wb_valid, wb_tag, wb_pkt, flush,
    output alloc_ready, alloc_tag, mon_valid, mon_order, mon_halt, mon_pkt,
           occupancy, error
  );
endinterface

// File: rtl/rvfi_retire_rob.sv
// In-order retirement buffer feeding the RVFI monitor; out-of-order writeback by tag.
// Optional protocol checker enabled by defining RVFI_ROB_CHECK_EN.

// One buffer slot: alloc/done flags plus the stored commit record.
module rvfi_rob_entry (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_alloc,
  input  logic         i_wr,
  input  logic         i_retire,
  input  logic [310:0] i_pkt,
  output logic         o_alloc,
  output logic         o_done,
  output logic [310:0] o_pkt
);
  logic         r_alloc;
  logic         r_done;
  logic [310:0] r_pkt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_alloc <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_flush) begin
      r_alloc <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_alloc <= 1'b1;
        r_done  <= 1'b0;
      end else if (i_retire) begin
        r_alloc <= 1'b0;
      end
      if (i_wr) r_done <= 1'b1;
    end
  end

  // Record storage needs no reset: done=0 masks it until written.
  always_ff @(posedge i_clk) begin
    if (i_wr) r_pkt <= i_pkt;
  end

  assign o_alloc = r_alloc;
  assign o_done  = r_done;
  assign o_pkt   = r_pkt;
endmodule

module rvfi_retire_rob #(
  parameter  int DEPTH = 8,
  localparam int TAGW  = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rvfi_retire_rob_if.slave   bus
);
  localparam logic [31:0] HALT_INST = 32'h0000_0063;

  logic [TAGW:0]  r_head;
  logic [TAGW:0]  r_tail;
  logic [63:0]    r_retire_cnt;
  logic           r_halted;
  logic           r_mon_valid;
  logic [63:0]    r_mon_order;
  logic           r_mon_halt;
  logic [310:0]   r_mon_pkt;

  logic [DEPTH-1:0]          w_ent_alloc;
  logic [DEPTH-1:0]          w_ent_done;
  logic [DEPTH-1:0][310:0]   w_ent_pkt;

  logic [TAGW:0]   w_occ;
  logic            w_ready;
  logic [TAGW-1:0] w_head_idx;
  logic [TAGW-1:0] w_tail_idx;
  logic            w_alloc_fire;
  logic            w_wb_ok;
  logic            w_retire;
  logic [310:0]    w_head_pkt;
  logic            w_is_halt;

  assign w_occ      = r_tail - r_head;
  assign w_ready    = (w_occ != (TAGW+1)'(DEPTH)) && !r_halted;
  assign w_head_idx = r_head[TAGW-1:0];
  assign w_tail_idx = r_tail[TAGW-1:0];
  assign w_head_pkt = w_ent_pkt[w_head_idx];
  assign w_is_halt  = (w_head_pkt[310:279] == HALT_INST);

  // Flush dominates every other event in the same cycle.
  assign w_alloc_fire = bus.alloc_req && w_ready && !bus.flush;
  assign w_wb_ok      = bus.wb_valid && w_ent_alloc[bus.wb_tag] &&
                        !w_ent_done[bus.wb_tag] && !bus.flush;
  assign w_retire     = w_ent_alloc[w_head_idx] && w_ent_done[w_head_idx] &&
                        !r_halted && !bus.flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rvfi_rob_entry u_ent (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_flush  (bus.flush),
      .i_alloc  (w_alloc_fire && (w_tail_idx == TAGW'(g))),
      .i_wr     (w_wb_ok && (bus.wb_tag == TAGW'(g))),
      .i_retire (w_retire && (w_head_idx == TAGW'(g))),
      .i_pkt    (bus.wb_pkt),
      .o_alloc  (w_ent_alloc[g]),
      .o_done   (w_ent_done[g]),
      .o_pkt    (w_ent_pkt[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_retire_cnt <= '0;
      r_halted     <= 1'b0;
      r_mon_valid  <= 1'b0;
      r_mon_order  <= '0;
      r_mon_halt   <= 1'b0;
      r_mon_pkt    <= '0;
    end else begin
      r_mon_valid <= w_retire;
      if (bus.flush) begin
        r_tail <= r_head;
      end else if (w_alloc_fire) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_head       <= r_head + 1'b1;
        r_retire_cnt <= r_retire_cnt + 64'd1;
        r_mon_order  <= r_retire_cnt;
        r_mon_halt   <= w_is_halt;
        r_mon_pkt    <= w_head_pkt;
        if (w_is_halt) r_halted <= 1'b1;
      end
    end
  end

  assign bus.alloc_ready = w_ready;
  assign bus.alloc_tag   = w_tail_idx;
  assign bus.occupancy   = w_occ;
  assign bus.mon_valid   = r_mon_valid;
  assign bus.mon_order   = r_mon_order;
  assign bus.mon_halt    = r_mon_halt;
  assign bus.mon_pkt     = r_mon_pkt;

`ifdef RVFI_ROB_CHECK_EN
  logic r_error;
  logic w_err_evt;

  assign w_err_evt = (bus.wb_valid && !(w_ent_alloc[bus.wb_tag] && !w_ent_done[bus.wb_tag])) ||
                     (bus.alloc_req && !w_ready && !r_halted) ||
                     (bus.wb_valid && bus.flush);

  always_ff @(posedge i_clk) begin
    if (!i_rst)         r_error <= 1'b0;
    else if (w_err_evt) r_error <= 1'b1;
  end

  assign bus.error = r_error;
`else
  assign bus.error = 1'b0;
`endif
endmodule

// File: tb/tb_rvfi_retire_rob.sv
// Randomized + directed bench for rvfi_retire_rob against a queue-based program-order model.
module tb_rvfi_retire_rob;
  localparam int DEPTH = 8;
  localparam int TAGW  = $clog2(DEPTH);

  typedef struct {
    int           tag;
    bit           done;
    logic [310:0] pkt;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rvfi_retire_rob_if #(.DEPTH(DEPTH)) bus ();

  rvfi_retire_rob #(.DEPTH(DEPTH)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending instructions in program order.
  ent_t         q[$];
  int           m_head;
  longint       m_cnt;
  bit           m_halt;
  bit           m_err;
  logic [310:0] m_last;

  task automatic chk(input string tag, input logic [310:0] obs, input logic [310:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [310:0] mkpkt(input bit halt);
    logic [310:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = $urandom();
    p[310:288] = 23'($urandom());
    if (halt) p[310:279] = 32'h0000_0063;
    else if (p[310:279] == 32'h0000_0063) p[279] = 1'b0;
    return p;
  endfunction

  function automatic int pick_pending();
    int c[$];
    foreach (q[i]) if (!q[i].done) c.push_back(q[i].tag);
    if (c.size() == 0) return -1;
    return c[$urandom_range(c.size()-1)];
  endfunction

  task automatic model_reset();
    q.delete();
    m_head = 0;
    m_cnt  = 0;
    m_halt = 0;
    m_err  = 0;
    m_last = '0;
  endtask

  task automatic step(input bit areq, input bit wv, input int wtag,
                      input logic [310:0] wpkt, input bit fl);
    bit           exp_ready, e_valid, e_halt;
    int           exp_tag, idx;
    longint       e_order;
    logic [310:0] e_pkt;
    bus.alloc_req = areq;
    bus.wb_valid  = wv;
    bus.wb_tag    = TAGW'(wtag);
    bus.wb_pkt    = wpkt;
    bus.flush     = fl;
    #1;
    exp_ready = (q.size() < DEPTH) && !m_halt;
    exp_tag   = (m_head + q.size()) % DEPTH;
    chk("alloc_ready", 311'(bus.alloc_ready), 311'(exp_ready));
    chk("alloc_tag",   311'(bus.alloc_tag),   311'(exp_tag));
    chk("occupancy",   311'(bus.occupancy),   311'(q.size()));

    idx = -1;
    foreach (q[i]) if (q[i].tag == (wtag % DEPTH) && !q[i].done) idx = i;
`ifdef RVFI_ROB_CHECK_EN
    if ((wv && idx < 0) || (areq && !exp_ready && !m_halt) || (wv && fl)) m_err = 1;
`endif
    e_valid = 0; e_halt = 0; e_order = 0; e_pkt = '0;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].done && !m_halt) begin
        e_valid = 1;
        e_pkt   = q[0].pkt;
        e_order = m_cnt;
        e_halt  = (q[0].pkt[310:279] == 32'h0000_0063);
      end
      if (wv && idx >= 0) begin
        q[idx].done = 1;
        q[idx].pkt  = wpkt;
      end
      if (e_valid) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % DEPTH;
        m_cnt++;
        if (e_halt) m_halt = 1;
      end
      if (areq && exp_ready) q.push_back('{tag: exp_tag, done: 0, pkt: '0});
    end

    @(posedge clk); #1;
    chk("mon_valid", 311'(bus.mon_valid), 311'(e_valid));
    if (e_valid) begin
      chk("mon_order", 311'(bus.mon_order), 311'(e_order));
      chk("mon_halt",  311'(bus.mon_halt),  311'(e_halt));
      chk("mon_pkt",   bus.mon_pkt, e_pkt);
      m_last = e_pkt;
    end else begin
      chk("mon_pkt_hold", bus.mon_pkt, m_last);
    end
    chk("error", 311'(bus.error), 311'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.alloc_req = 0; bus.wb_valid = 0; bus.wb_tag = '0; bus.wb_pkt = '0; bus.flush = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    chk("rst_mon_valid",   311'(bus.mon_valid),   311'(0));
    chk("rst_mon_order",   311'(bus.mon_order),   311'(0));
    chk("rst_mon_halt",    311'(bus.mon_halt),    311'(0));
    chk("rst_mon_pkt",     bus.mon_pkt,           311'(0));
    chk("rst_error",       311'(bus.error),       311'(0));
    chk("rst_alloc_ready", 311'(bus.alloc_ready), 311'(1));
    chk("rst_alloc_tag",   311'(bus.alloc_tag),   311'(0));
    chk("rst_occupancy",   311'(bus.occupancy),   311'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, 0);
  endtask

  task automatic allocs(input int n);
    repeat (n) step(1, 0, 0, '0, 0);
  endtask

  task automatic rand_cycles(input int n, input int flush_pct);
    int t;
    bit wv;
    repeat (n) begin
      t  = pick_pending();
      wv = ($urandom_range(99) < 60);
      if (t < 0 || $urandom_range(9) == 0) t = $urandom_range(DEPTH-1);
      step($urandom_range(2) != 0, wv, t, mkpkt(0), $urandom_range(99) < flush_pct);
    end
  endtask

  initial begin
    int tags[$];
    do_reset();

    // In-order: 4 allocations, writebacks on consecutive cycles
    allocs(4);
    tags.delete(); foreach (q[i]) tags.push_back(q[i].tag);
    foreach (tags[i]) step(0, 1, tags[i], mkpkt(0), 0);
    idle(3);

    // Out-of-order writeback 2,1,0
    allocs(3);
    tags.delete(); foreach (q[i]) tags.push_back(q[i].tag);
    for (int i = 2; i >= 0; i--) step(0, 1, tags[i], mkpkt(0), 0);
    idle(4);

    // Full, dropped 9th request, then wrap with 8 more
    allocs(9);
    tags.delete(); foreach (q[i]) tags.push_back(q[i].tag);
    foreach (tags[i]) step(0, 1, tags[i], mkpkt(0), 0);
    allocs(8);
    tags.delete(); foreach (q[i]) tags.push_back(q[i].tag);
    foreach (tags[i]) step(0, 1, tags[i], mkpkt(0), 0);
    idle(10);

    rand_cycles(400, 3);
    idle(12);

    // Flush with alloc_req and writeback in flight
    allocs(3);
    step(1, 1, q[0].tag, mkpkt(0), 1);
    allocs(2);
    tags.delete(); foreach (q[i]) tags.push_back(q[i].tag);
    foreach (tags[i]) step(0, 1, tags[i], mkpkt(0), 0);
    idle(3);

    // Halt at order 5; entry behind it is done but must never retire
    do_reset();
    allocs(5);
    tags.delete(); foreach (q[i]) tags.push_back(q[i].tag);
    foreach (tags[i]) step(0, 1, tags[i], mkpkt(0), 0);
    idle(3);
    allocs(2);
    step(0, 1, q[1].tag, mkpkt(0), 0);
    step(0, 1, q[0].tag, mkpkt(1), 0);
    idle(4);
    allocs(3);
    rand_cycles(20, 0);

    // Reset mid-operation, then a short random run from order 0
    allocs(3);
    do_reset();
`ifdef RVFI_ROB_CHECK_EN
    step(0, 1, 6, mkpkt(0), 0);
    idle(3);
    do_reset();
`endif
    rand_cycles(60, 2);
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
